// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the Karpentium fetch stage: widths, opcodes, PC control
// codes and fetch FSM state encodings. The program counter uses the same PC codes.
package fetch_unit_pkg;

  localparam int unsigned AddrW  = 6;
  localparam int unsigned InstrW = 16;
  localparam int unsigned OpW    = 4;

  localparam logic [OpW-1:0] OpJmp = 4'hF;
  localparam logic [OpW-1:0] OpHlt = 4'hE;

  typedef enum logic [1:0] {
    PcHold = 2'b00,
    PcInc  = 2'b01,
    PcLoad = 2'b10
  } pc_ctrl_e;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StIssue = 2'b01,
    StDrain = 2'b10,
    StHalt  = 2'b11
  } fetch_state_e;

  function automatic logic [OpW-1:0] opcode_of(input logic [InstrW-1:0] word);
    return word[InstrW-1 -: OpW];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's PC, instruction-memory, decode and redirect signals.
// master is the fetch side; slave is the surrounding pipeline and memory.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [AddrW-1:0]  pc_addr;
  logic [1:0]        pc_ctrl;
  logic [AddrW-1:0]  pc_in;
  logic              mem_rd;
  logic [AddrW-1:0]  mem_addr;
  logic              mem_ack;
  logic [InstrW-1:0] mem_data;
  logic [InstrW-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [AddrW-1:0]  redirect_addr;
  logic              halted;

  modport master (
    input  pc_addr,
    output pc_ctrl,
    output pc_in,
    output mem_rd,
    output mem_addr,
    input  mem_ack,
    input  mem_data,
    output instr,
    output instr_valid,
    input  instr_ready,
    input  redirect,
    input  redirect_addr,
    output halted
  );

  modport slave (
    output pc_addr,
    input  pc_ctrl,
    input  pc_in,
    input  mem_rd,
    input  mem_addr,
    output mem_ack,
    output mem_data,
    input  instr,
    input  instr_valid,
    output instr_ready,
    output redirect,
    output redirect_addr,
    input  halted
  );

endinterface

// File: rtl/fetch_opdecode.sv
// Combinational pre-decode of a fetched word: flags JMP and HLT and extracts the
// jump target so the fetch FSM can resolve them without involving decode.
module fetch_opdecode
  import fetch_unit_pkg::*;
(
  input  logic [InstrW-1:0] data_i,
  output logic              is_jmp_o,
  output logic              is_hlt_o,
  output logic [AddrW-1:0]  jmp_target_o
);

  logic unused_bits;

  assign is_jmp_o     = (opcode_of(data_i) == OpJmp);
  assign is_hlt_o     = (opcode_of(data_i) == OpHlt);
  assign jmp_target_o = data_i[AddrW-1:0];
  assign unused_bits  = ^data_i[InstrW-OpW-1:AddrW];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, reads instruction memory over req/ack,
// holds the IR for decode, resolves JMP/HLT locally and accepts execute redirects.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  fetch_unit_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [InstrW-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  pc_ctrl_e          pc_ctrl;
  logic [AddrW-1:0]  pc_in;
  logic              mem_rd;

  logic              is_jmp;
  logic              is_hlt;
  logic [AddrW-1:0]  jmp_target;

  fetch_opdecode u_opdecode (
    .data_i       (bus.mem_data),
    .is_jmp_o     (is_jmp),
    .is_hlt_o     (is_hlt),
    .jmp_target_o (jmp_target)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    pc_ctrl  = PcHold;
    pc_in    = '0;
    mem_rd   = 1'b0;

    if (valid_q && bus.instr_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StFetch: begin
        mem_rd = 1'b1;
        if (bus.mem_ack) begin
          if (is_jmp) begin
            pc_ctrl = PcLoad;
            pc_in   = jmp_target;
          end else begin
            instr_d = bus.mem_data;
            valid_d = 1'b1;
            if (is_hlt) begin
              state_d  = StHalt;
              halted_d = 1'b1;
            end else begin
              pc_ctrl = PcInc;
              state_d = StIssue;
            end
          end
        end
      end
      StIssue: begin
        if (valid_q && bus.instr_ready) begin
          state_d = StFetch;
        end
      end
      StDrain: begin
        // Stale request from before a redirect; its data must be dropped.
        mem_rd = 1'b1;
        if (bus.mem_ack) begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (bus.redirect) begin
      pc_ctrl  = PcLoad;
      pc_in    = bus.redirect_addr;
      instr_d  = instr_q;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      state_d  = (state_q == StFetch && !bus.mem_ack) ? StDrain : StFetch;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StFetch;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc_ctrl     = pc_ctrl;
  assign bus.pc_in       = pc_in;
  assign bus.mem_rd      = mem_rd;
  assign bus.mem_addr    = bus.pc_addr;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a PC, a latency-programmable instruction memory, directed
// scenarios, then a random program checked against a program-walk reference.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  logic [15:0] mem [64];
  int          lat      = 2;
  bit          rand_lat = 1'b0;
  bit          busy     = 1'b0;
  int          cnt      = 0;
  logic [5:0]  req_addr = '0;

  int n_chk  = 0;
  int n_fail = 0;

  // Program counter the fetch stage controls.
  always @(posedge clk) begin
    if (clr)                      bus.pc_addr <= '0;
    else if (bus.pc_ctrl == 2'b01) bus.pc_addr <= bus.pc_addr + 6'd1;
    else if (bus.pc_ctrl == 2'b10) bus.pc_addr <= bus.pc_in;
  end

  // Memory: latches the address when a request starts, acks after cnt wait cycles.
  always @(negedge clk) begin
    if (clr) begin
      busy         = 1'b0;
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
    end else begin
      if (bus.mem_ack) busy = 1'b0;
      bus.mem_ack = 1'b0;
      if (bus.mem_rd) begin
        if (!busy) begin
          busy     = 1'b1;
          req_addr = bus.mem_addr;
          cnt      = rand_lat ? int'($urandom_range(0, 3)) : lat;
        end
        if (cnt == 0) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = mem[req_addr];
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int waits);
    waits = 0;
    mid;
    while (!bus.mem_ack && waits < 20) begin
      waits++;
      mid;
    end
    check("ack_seen", bus.mem_ack, 1);
  endtask

  // Reference: walk the program as the architecture defines it.
  function automatic logic [15:0] walk_next(inout logic [5:0] pc);
    logic [15:0] w;
    for (int k = 0; k < 64; k++) begin
      w = mem[pc];
      if (w[15:12] == 4'hF) begin
        pc = w[5:0];
      end else begin
        pc = pc + 6'd1;
        return w;
      end
    end
    return 16'hxxxx;
  endfunction

  initial begin
    int          waits;
    int          got;
    logic [15:0] exp_q[$];
    logic [15:0] w;
    logic [5:0]  wpc;
    logic [5:0]  t;

    bus.instr_ready   = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h00] = 16'h1234;
    mem[6'h01] = 16'h2345;
    mem[6'h02] = 16'hF02A;
    mem[6'h2A] = 16'hBEEF;
    mem[6'h10] = 16'hE000;
    mem[6'h05] = 16'h1111;

    // Reset
    clr = 1'b1;
    mid;
    mid;
    clr = 1'b0;
    check("rst_mem_rd", bus.mem_rd, 1);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_pc_ctrl", bus.pc_ctrl, 0);
    check("rst_instr", bus.instr, 0);

    // Sequential fetch with two wait cycles
    wait_ack(waits);
    check("seq_waits", waits, 2);
    check("seq_ack_pc_ctrl", bus.pc_ctrl, 2'b01);
    check("seq_ack_addr", bus.mem_addr, 0);
    mid;
    check("seq_instr", bus.instr, 16'h1234);
    check("seq_valid", bus.instr_valid, 1);
    check("seq_pc", bus.pc_addr, 1);
    mid;
    check("seq_next_addr", bus.mem_addr, 1);
    check("seq_next_rd", bus.mem_rd, 1);

    // Backpressure
    bus.instr_ready = 1'b0;
    wait_ack(waits);
    check("bp_ack_pc_ctrl", bus.pc_ctrl, 2'b01);
    for (int i = 0; i < 5; i++) begin
      mid;
      check("bp_instr", bus.instr, 16'h2345);
      check("bp_valid", bus.instr_valid, 1);
      check("bp_pc_ctrl", bus.pc_ctrl, 0);
      check("bp_mem_rd", bus.mem_rd, 0);
    end
    check("bp_pc_held", bus.pc_addr, 2);
    bus.instr_ready = 1'b1;
    mid;
    check("bp_release_valid", bus.instr_valid, 0);
    check("bp_release_addr", bus.mem_addr, 2);

    // JMP resolved locally
    wait_ack(waits);
    check("jmp_pc_ctrl", bus.pc_ctrl, 2'b10);
    check("jmp_pc_in", bus.pc_in, 6'h2A);
    lat = 4;
    mid;
    check("jmp_valid", bus.instr_valid, 0);
    check("jmp_instr_kept", bus.instr, 16'h2345);
    check("jmp_next_addr", bus.mem_addr, 6'h2A);

    // Redirect while waiting for ack
    mid;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 6'h10;
    lat = 1;
    #1;
    check("rd_no_ack_yet", bus.mem_ack, 0);
    check("rd_pc_ctrl", bus.pc_ctrl, 2'b10);
    check("rd_pc_in", bus.pc_in, 6'h10);
    mid;
    bus.redirect = 1'b0;
    #1;
    check("rd_pc", bus.pc_addr, 6'h10);
    check("rd_drain_rd", bus.mem_rd, 1);
    check("rd_drain_pc_ctrl", bus.pc_ctrl, 0);
    wait_ack(waits);
    check("rd_late_pc_ctrl", bus.pc_ctrl, 0);
    mid;
    check("rd_late_valid", bus.instr_valid, 0);
    check("rd_late_instr", bus.instr, 16'h2345);
    check("rd_refetch_addr", bus.mem_addr, 6'h10);
    check("rd_refetch_rd", bus.mem_rd, 1);

    // HLT
    wait_ack(waits);
    check("hlt_ack_pc_ctrl", bus.pc_ctrl, 0);
    mid;
    check("hlt_instr", bus.instr, 16'hE000);
    check("hlt_valid", bus.instr_valid, 1);
    check("hlt_halted", bus.halted, 1);
    for (int i = 0; i < 5; i++) begin
      mid;
      check("hlt_mem_rd", bus.mem_rd, 0);
      check("hlt_pc_ctrl", bus.pc_ctrl, 0);
      check("hlt_stays", bus.halted, 1);
      check("hlt_valid_cleared", bus.instr_valid, 0);
    end
    bus.redirect      = 1'b1;
    bus.redirect_addr = 6'h05;
    #1;
    check("hlt_rd_pc_ctrl", bus.pc_ctrl, 2'b10);
    check("hlt_rd_pc_in", bus.pc_in, 6'h05);
    mid;
    bus.redirect = 1'b0;
    #1;
    check("hlt_rd_halted", bus.halted, 0);
    check("hlt_rd_addr", bus.mem_addr, 6'h05);
    check("hlt_rd_rd", bus.mem_rd, 1);

    // clr beats a simultaneous redirect and ack
    mid;
    check("clr_ack_present", bus.mem_ack, 1);
    bus.redirect      = 1'b1;
    bus.redirect_addr = 6'h3F;
    clr               = 1'b1;
    mid;
    clr          = 1'b0;
    bus.redirect = 1'b0;
    #1;
    check("clr_addr", bus.mem_addr, 0);
    check("clr_valid", bus.instr_valid, 0);
    check("clr_instr", bus.instr, 0);
    check("clr_mem_rd", bus.mem_rd, 1);

    // Random program, random latency and random decode readiness
    clr = 1'b1;
    mid;
    mid;
    for (int i = 0; i < 64; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hE) w[15:12] = 4'h0;
      mem[i] = w;
    end
    if (mem[0][15:12] == 4'hF) mem[0][15:12] = 4'h1;
    for (int i = 0; i < 64; i++) begin
      if (mem[i][15:12] == 4'hF) begin
        t = 6'($urandom);
        for (int k = 0; k < 64 && mem[t][15:12] == 4'hF; k++) t = t + 6'd1;
        mem[i][5:0] = t;
      end
    end
    wpc = '0;
    for (int i = 0; i < 80; i++) exp_q.push_back(walk_next(wpc));
    rand_lat = 1'b1;
    clr      = 1'b0;
    got      = 0;
    for (int c = 0; c < 4000 && got < 80; c++) begin
      mid;
      bus.instr_ready = 1'($urandom_range(0, 1));
      #1;
      check("pc_ctrl_legal", bus.pc_ctrl != 2'b11, 1);
      if (bus.instr_valid && bus.instr_ready) begin
        check("stream_instr", bus.instr, exp_q.pop_front());
        got++;
      end
    end
    check("stream_count", got, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
